// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 geometry and derived line/frame totals.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Decode of an axis position that the counter is about to enter.
  typedef struct packed {
    logic active;
    logic sync;
  } axis_flags_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter, terminal-count flag and decode of the
// position being entered so the parent can register its outputs in step with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic             tc,
  output axis_flags_t      flags_next
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = LAST;
    end else if (step) begin
      count_d = tc_q ? '0 : count_q + ONE;
    end
    tc_d = (count_d == LAST);
    // A restart parks the axis at its last position with every decode forced low.
    flags_next.active = !restart && (count_d < ACT_END);
    flags_next.sync   = !restart && (count_d >= SYNC_BEG) && (count_d < SYNC_END);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= LAST;
      tc_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: rtl/vga_timer.sv
// VGA raster timer: horizontal and vertical axis counters plus registered
// active/sync decode, line/frame start pulses and a wrapping frame counter.
module vga_timer
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       restart,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       new_line,
  output logic       new_frame,
  output logic [7:0] frame_count
);

  logic        h_step, v_step;
  logic        h_tc, v_tc;
  axis_flags_t h_flags_next, v_flags_next;

  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       new_line_q, new_line_d;
  logic       new_frame_q, new_frame_d;
  logic [7:0] frame_count_q, frame_count_d;

  // Restart wins over en, so neither axis steps in a restart cycle.
  assign h_step = en && !restart;
  assign v_step = h_step && h_tc;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .step      (h_step),
    .restart   (restart),
    .count     (x),
    .tc        (h_tc),
    .flags_next(h_flags_next)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .step      (v_step),
    .restart   (restart),
    .count     (y),
    .tc        (v_tc),
    .flags_next(v_flags_next)
  );

  // Decoding the positions being entered keeps these flops aligned with x/y.
  always_comb begin
    active_d      = h_flags_next.active && v_flags_next.active;
    hsync_d       = h_flags_next.sync;
    vsync_d       = v_flags_next.sync;
    new_line_d    = h_step && h_tc;
    new_frame_d   = v_step && v_tc;
    frame_count_d = frame_count_q + {7'd0, new_frame_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      new_line_q    <= 1'b0;
      new_frame_q   <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      new_line_q    <= new_line_d;
      new_frame_q   <= new_frame_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign new_line    = new_line_q;
  assign new_frame   = new_frame_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timer.sv
// Scoreboarded bench for vga_timer on a reduced raster, with a position-level reference model.
module tb_vga_timer;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] x, y;
  logic       active, hsync, vsync, new_line, new_frame;
  logic [7:0] frame_count;

  vga_timer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .restart    (restart),
    .x          (x),
    .y          (y),
    .active     (active),
    .hsync      (hsync),
    .vsync      (vsync),
    .new_line   (new_line),
    .new_frame  (new_frame),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       nl;
    logic       nf;
    logic [7:0] fc;
  } obs_t;

  obs_t exp_q[$];
  obs_t imm;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mx, my, mfc;
  bit   mnl, mnf;

  task automatic check(input string name, input int act_v, input int exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
    end
  endtask

  // Raster position model: a pixel tick advances x, wrapping x advances y.
  task automatic model_step(input bit r_n, input bit e, input bit rs);
    mnl = 1'b0;
    mnf = 1'b0;
    if (!r_n) begin
      mx = HT - 1; my = VT - 1; mfc = 0;
    end else if (rs) begin
      mx = HT - 1; my = VT - 1;
    end else if (e) begin
      mx = mx + 1;
      if (mx == HT) begin
        mx = 0;
        my = (my + 1) % VT;
      end
      if (mx == 0) begin
        mnl = 1'b1;
        if (my == 0) begin
          mnf = 1'b1;
          mfc = (mfc + 1) % 256;
        end
      end
    end
  endtask

  function automatic obs_t expected();
    obs_t o;
    o.x   = 10'(mx);
    o.y   = 10'(my);
    o.act = (mx < HA) && (my < VA);
    o.hs  = (mx >= HA + HF) && (mx < HA + HF + HS);
    o.vs  = (my >= VA + VF) && (my < VA + VF + VS);
    o.nl  = mnl;
    o.nf  = mnf;
    o.fc  = 8'(mfc);
    return o;
  endfunction

  task automatic cyc(input bit r_n, input bit e, input bit rs);
    @(negedge clk);
    reset_n = r_n;
    en      = e;
    restart = rs;
    model_step(r_n, e, rs);
    exp_q.push_back(expected());
    #1 imm = {x, y, active, hsync, vsync, new_line, new_frame, frame_count};
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    obs_t e_o, a_o;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e_o = exp_q.pop_front();
        a_o = {x, y, active, hsync, vsync, new_line, new_frame, frame_count};
        n_cmp++;
        if (a_o !== e_o) begin
          n_bad++;
          $display("FAIL scoreboard: got x=%0d y=%0d act=%b hs=%b vs=%b nl=%b nf=%b fc=%0d, expected x=%0d y=%0d act=%b hs=%b vs=%b nl=%b nf=%b fc=%0d",
                   a_o.x, a_o.y, a_o.act, a_o.hs, a_o.vs, a_o.nl, a_o.nf, a_o.fc,
                   e_o.x, e_o.y, e_o.act, e_o.hs, e_o.vs, e_o.nl, e_o.nf, e_o.fc);
        end
      end
    end
  end

  initial begin : stimulus
    int cnt, fc0, last_nl, bad_nl, nl_cnt, run, max_run;
    int hs_cnt, hs_min, hs_max, act_cnt, vs_cnt, vs_min, vs_max, act_bottom;
    bit seen;
    mx = HT - 1; my = VT - 1; mfc = 0;

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    check("reset_x", imm.x, HT - 1);
    check("reset_y", imm.y, VT - 1);
    check("reset_pulses", {imm.act, imm.hs, imm.vs, imm.nl, imm.nf}, 0);
    check("reset_fc", imm.fc, 0);

    cyc(1'b1, 1'b1, 1'b0);
    check("first_nf", new_frame, 1);
    check("first_nl", new_line, 1);
    check("first_xy", {x, y}, 0);
    check("first_fc", frame_count, 1);

    cnt = 0; seen = 0;
    for (int i = 0; i < FR + 10 && !seen; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      cnt++;
      if (new_frame) seen = 1;
    end
    check("frame_period", cnt, FR);
    check("second_fc", frame_count, 2);

    hs_cnt = 0; hs_min = 1023; hs_max = -1; act_cnt = 0;
    vs_cnt = 0; vs_min = 1023; vs_max = -1; act_bottom = 0;
    last_nl = -1; bad_nl = 0; nl_cnt = 0;
    for (int i = 0; i < FR; i++) begin
      if (y == 10) begin
        if (hsync) begin
          hs_cnt++;
          if (int'(x) < hs_min) hs_min = int'(x);
          if (int'(x) > hs_max) hs_max = int'(x);
        end
        if (active) act_cnt++;
      end
      if (vsync) begin
        vs_cnt++;
        if (int'(y) < vs_min) vs_min = int'(y);
        if (int'(y) > vs_max) vs_max = int'(y);
      end
      if (active && y >= VA) act_bottom++;
      if (new_line) begin
        nl_cnt++;
        if (last_nl >= 0 && i - last_nl != HT) bad_nl++;
        last_nl = i;
      end
      cyc(1'b1, 1'b1, 1'b0);
    end
    check("hs_width", hs_cnt, HS);
    check("hs_first_x", hs_min, HA + HF);
    check("hs_last_x", hs_max, HA + HF + HS - 1);
    check("active_width", act_cnt, HA);
    check("vs_cycles", vs_cnt, VS * HT);
    check("vs_first_y", vs_min, VA + VF);
    check("vs_last_y", vs_max, VA + VF + VS - 1);
    check("active_blank", act_bottom, 0);
    check("nl_count", nl_cnt, VT);
    check("nl_period", bad_nl, 0);

    cnt = 0; seen = 0; nl_cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 2 * FR + 10 && !seen; i++) begin
      cyc(1'b1, (i % 2) == 1, 1'b0);
      cnt++;
      if (new_line) begin
        nl_cnt++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (new_frame) seen = 1;
    end
    check("toggle_frame_period", cnt, 2 * FR);
    check("toggle_nl_count", nl_cnt, VT);
    check("toggle_nl_width", max_run, 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("toggle_nf_width", new_frame, 0);

    for (int i = 0; i < FR && !(x == 10'd15 && y == 10'd7); i++) cyc(1'b1, 1'b1, 1'b0);
    check("restart_reached", {x, y}, {10'd15, 10'd7});
    fc0 = int'(frame_count);
    cyc(1'b1, 1'b1, 1'b1);
    check("restart_x", x, HT - 1);
    check("restart_y", y, VT - 1);
    check("restart_outs", {active, hsync, vsync, new_line, new_frame}, 0);
    check("restart_fc", frame_count, fc0);
    cyc(1'b1, 1'b1, 1'b0);
    check("restart_nf", new_frame, 1);
    check("restart_fc_inc", frame_count, (fc0 + 1) % 256);

    for (int i = 0; i < 8 * FR && frame_count != 8'd5; i++) cyc(1'b1, 1'b1, 1'b0);
    check("fc_reached_5", frame_count, 5);
    for (int i = 0; i < FR && !(x == 10'(HA / 2) && y == 10'(VA / 2)); i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("async_reset_x", imm.x, HT - 1);
    check("async_reset_y", imm.y, VT - 1);
    check("async_reset_outs", {imm.act, imm.hs, imm.vs, imm.nl, imm.nf}, 0);
    check("async_reset_fc", imm.fc, 0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("post_reset_nf", new_frame, 1);
    check("post_reset_fc", frame_count, 1);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 511) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timer.md
VGA_TIMER -- requirements
Module: vga_timer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-010 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port en, input, 1, pixel enable; the counters advance only in cycles where en=1.
REQ-012 SHALL have port restart, input, 1, synchronous request to restart the frame.
REQ-013 SHALL have port x, output, 10, current horizontal position.
REQ-014 SHALL have port y, output, 10, current vertical position.
REQ-015 SHALL have port active, output, 1, high while the current position is visible.
REQ-016 SHALL have port hsync, output, 1, active-high horizontal sync; the top level inverts it for the pins.
REQ-017 SHALL have port vsync, output, 1, active-high vertical sync; the top level inverts it for the pins.
REQ-018 SHALL have port new_line, output, 1, one-cycle pulse at the start of each line.
REQ-019 SHALL have port new_frame, output, 1, one-cycle pulse at the start of each frame.
REQ-020 SHALL have port frame_count, output, 8, count of frames started, wrapping.

Function
REQ-021 SHALL define H_TOTAL as H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL as V_ACTIVE+V_FP+V_SYNC+V_BP, both below 1024.
REQ-022 SHALL, when en=1, step x as x+1 and wrap it from H_TOTAL-1 to 0.
REQ-023 SHALL step y, wrapping from V_TOTAL-1 to 0, only when en=1 and x wraps.
REQ-024 SHALL register all outputs so that active, hsync and vsync always decode the current x and y, with zero-cycle skew between them.
REQ-025 SHALL drive active=1 exactly when x<H_ACTIVE and y<V_ACTIVE.
REQ-026 SHALL drive hsync=1 exactly when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
REQ-027 SHALL drive vsync=1 exactly when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for the whole of each such line.
REQ-028 SHALL assert new_line for exactly one clk cycle, the first cycle in which x=0; it SHALL NOT be held over repeated en=0 cycles.
REQ-029 SHALL assert new_frame for exactly one clk cycle, the first cycle in which x=0 and y=0, and SHALL increment frame_count by one (mod 256) in that same cycle.
REQ-030 SHALL hold all state and outputs when en=0, and SHALL hold new_line and new_frame low in those cycles.
REQ-031 SHALL, when restart=1, load x=H_TOTAL-1 and y=V_TOTAL-1 on the next edge, with active, hsync, vsync, new_line and new_frame low and frame_count unchanged.
REQ-032 SHALL give restart priority over en when both are asserted in the same cycle.

Reset
REQ-033 SHALL, while reset_n=0, force x=H_TOTAL-1, y=V_TOTAL-1, active=0, hsync=0, vsync=0, new_line=0, new_frame=0 and frame_count=0, independent of clk.
REQ-034 SHALL, on the first en=1 cycle after reset release, enter x=0, y=0 and pulse new_frame and new_line.
REQ-035 SHALL, if reset_n is asserted mid-line, abandon that frame immediately with no partial pulses.

Structure
REQ-036 SHALL take the default timing constants, and the derived H_TOTAL and V_TOTAL, from shared package vga_timing_pkg.
REQ-037 SHALL implement each axis with one sub-module, vga_axis_counter (count, wrap, sync window, terminal-count flag), instantiated once for H and once for V.

Verification
REQ-038 Bench SHALL check: reset release, en=1 constantly -> new_frame in the first cycle with x=0,y=0; next new_frame 420000 cycles later; frame_count=1 then 2.
REQ-039 Bench SHALL check: en=1 constantly, y=10 -> hsync high for x=656..751 (96 cycles); active high for x=0..639; new_line period 800 cycles.
REQ-040 Bench SHALL check: en=1 constantly -> vsync high exactly for y=490 and 491 (1600 cycles); active=0 for y>=480.
REQ-041 Bench SHALL check: en toggling 1,0,1,0 -> x advances every second cycle; new_frame and new_line each pulse for one cycle only; one frame takes 840000 cycles.
REQ-042 Bench SHALL check: restart and en both high at x=300,y=200 -> next cycle x=799, y=524, outputs low; the following en=1 cycle pulses new_frame; frame_count increases by exactly 1 over the restart.
REQ-043 Bench SHALL check: reset_n low for 3 cycles mid-frame with frame_count=5 -> immediate reset values, including frame_count=0, without waiting for a clk edge.
